// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu: operation request in,
// ready/valid handshake and registered result out.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  ready_o, valid_o, data_o, zero_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output ready_o, valid_o, data_o, zero_o
  );
endinterface

// File: rtl/multicycle_alu.sv
// Single-cycle ALU with an iterative shift-and-add multiplier that takes
// WIDTH cycles; results are registered and announced with a valid pulse.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  multicycle_alu_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_res_s;
  logic [WIDTH-1:0] acc_step_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             last_iter_s;

  assign shamt_s     = bus.data2_i[SHW-1:0];
  assign accept_s    = bus.valid_i && (state_q == IDLE);
  assign is_mul_s    = (bus.ALUCtrl_i == OP_MUL);
  assign last_iter_s = (cnt_q == LAST_ITER);
  assign acc_step_s  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res_s = '0;
    case (bus.ALUCtrl_i)
      OP_AND:  alu_res_s = bus.data1_i & bus.data2_i;
      OP_XOR:  alu_res_s = bus.data1_i ^ bus.data2_i;
      OP_SLL:  alu_res_s = bus.data1_i << shamt_s;
      OP_ADD:  alu_res_s = bus.data1_i + bus.data2_i;
      OP_SUB:  alu_res_s = bus.data1_i - bus.data2_i;
      OP_ADDI: alu_res_s = bus.data1_i + bus.data2_i;
      OP_SRAI: alu_res_s = $signed(bus.data1_i) >>> shamt_s;
      default: alu_res_s = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && is_mul_s) state_d = MUL_BUSY;
        else                      state_d = IDLE;
      end
      MUL_BUSY: begin
        if (last_iter_s) state_d = IDLE;
        else             state_d = MUL_BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = 1'b0;
    case (state_q)
      IDLE:     bus.ready_o = 1'b1;
      MUL_BUSY: bus.ready_o = 1'b0;
      default:  bus.ready_o = 1'b0;
    endcase
  end

  // The last busy edge folds its own partial product straight into data_o.
  always_comb begin
    data_d   = data_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (state_q == MUL_BUSY) begin
      acc_d    = acc_step_s;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_iter_s) begin
        data_d  = acc_step_s;
        zero_d  = (acc_step_s == '0);
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (accept_s) begin
      if (is_mul_s) begin
        mcand_d  = bus.data1_i;
        mplier_d = bus.data2_i;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        data_d  = alu_res_s;
        zero_d  = (alu_res_s == '0);
        valid_d = 1'b1;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q   <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.zero_o  = zero_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: directed literal cases plus random traffic checked
// every cycle against a cycle-count/arithmetic reference model.
module tb_multicycle_alu;

  localparam logic [2:0] AND_ = 3'd0, XOR_ = 3'd1, SLL_ = 3'd2, ADD_ = 3'd3;
  localparam logic [2:0] SUB_ = 3'd4, MUL_ = 3'd5, ADDI_ = 3'd6, SRAI_ = 3'd7;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  multicycle_alu_if #(.WIDTH(32)) bus ();

  multicycle_alu #(.WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: results are plain arithmetic; MUL is just a countdown.
  logic [31:0] m_data  = 32'd0;
  logic        m_zero  = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pend  = 32'd0;
  int          m_busy  = 0;

  function automatic logic [31:0] alu_ref(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      AND_:    return a & b;
      XOR_:    return a ^ b;
      SLL_:    return a << b[4:0];
      ADD_:    return a + b;
      SUB_:    return a - b;
      MUL_:    return a * b;
      ADDI_:   return a + b;
      default: return sa >>> b[4:0];
    endcase
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_data  <= 32'd0;
      m_zero  <= 1'b0;
      m_valid <= 1'b0;
      m_busy  <= 0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_data  <= m_pend;
        m_zero  <= (m_pend == 32'd0);
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (bus.valid_i) begin
      if (bus.ALUCtrl_i == MUL_) begin
        m_pend  <= alu_ref(MUL_, bus.data1_i, bus.data2_i);
        m_busy  <= 32;
        m_valid <= 1'b0;
      end else begin
        m_data  <= alu_ref(bus.ALUCtrl_i, bus.data1_i, bus.data2_i);
        m_zero  <= (alu_ref(bus.ALUCtrl_i, bus.data1_i, bus.data2_i) == 32'd0);
        m_valid <= 1'b1;
      end
    end else begin
      m_valid <= 1'b0;
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(logic v, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    bus.valid_i   = v;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    check("model_valid_o", {63'd0, bus.valid_o}, {63'd0, m_valid});
    check("model_ready_o", {63'd0, bus.ready_o}, {63'd0, (m_busy == 0)});
    check("model_data_o",  {32'd0, bus.data_o},  {32'd0, m_data});
    check("model_zero_o",  {63'd0, bus.zero_o},  {63'd0, m_zero});
  end

  task automatic check_reset_now(string tag);
    check({tag, "_data"},  {32'd0, bus.data_o}, 64'd0);
    check({tag, "_valid"}, {63'd0, bus.valid_o}, 64'd0);
    check({tag, "_ready"}, {63'd0, bus.ready_o}, 64'd1);
    check({tag, "_zero"},  {63'd0, bus.zero_o}, 64'd0);
  endtask

  task automatic one_op(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp, logic expz);
    drive(1'b1, op, a, b);
    @(negedge clk_i);
    check({name, "_valid"}, {63'd0, bus.valid_o}, 64'd1);
    check({name, "_data"},  {32'd0, bus.data_o}, {32'd0, exp});
    check({name, "_zero"},  {63'd0, bus.zero_o}, {63'd0, expz});
  endtask

  task automatic run_mul(string name, logic [31:0] a, logic [31:0] b,
                         logic [31:0] exp, logic expz, logic hold_add);
    int n;
    int low;
    n   = 0;
    low = 0;
    drive(1'b1, MUL_, a, b);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if (hold_add) drive(1'b1, ADD_, 32'd1, 32'd1);
      else          drive(1'b0, ADD_, 32'd0, 32'd0);
      if (!bus.ready_o) low++;
      if (bus.valid_o) begin
        n = i;
        break;
      end
    end
    check({name, "_latency"}, 64'(n), 64'd33);
    check({name, "_busy_cycles"}, 64'(low), 64'd32);
    check({name, "_data"}, {32'd0, bus.data_o}, {32'd0, exp});
    check({name, "_zero"}, {63'd0, bus.zero_o}, {63'd0, expz});
    if (hold_add) begin
      @(negedge clk_i);
      drive(1'b0, ADD_, 32'd0, 32'd0);
      check({name, "_add_valid"}, {63'd0, bus.valid_o}, 64'd1);
      check({name, "_add_data"}, {32'd0, bus.data_o}, 64'd2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    logic [31:0] a, b;
    drive(1'b0, AND_, 32'd0, 32'd0);
    rst_i = 1'b0;
    #1 check_reset_now("reset_init");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    one_op("b2b_add", ADD_, 32'd5, 32'd3, 32'd8, 1'b0);
    one_op("b2b_sub", SUB_, 32'd3, 32'd3, 32'd0, 1'b1);
    one_op("b2b_and", AND_, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
    drive(1'b0, AND_, 32'd0, 32'd0);
    @(negedge clk_i);
    check("hold_valid", {63'd0, bus.valid_o}, 64'd0);
    check("hold_data", {32'd0, bus.data_o}, 64'hF000F000);

    one_op("sll", SLL_, 32'd1, 32'h21, 32'd2, 1'b0);
    one_op("srai", SRAI_, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
    one_op("xor", XOR_, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);
    one_op("addi_wrap", ADDI_, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0);

    run_mul("mul_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    run_mul("mul_zero", 32'd12345, 32'd0, 32'd0, 1'b1, 1'b0);
    run_mul("mul_busy", 32'd7, 32'd6, 32'h2A, 1'b0, 1'b1);

    // Abandon a multiply partway through.
    drive(1'b1, MUL_, 32'd3, 32'd4);
    @(negedge clk_i);
    drive(1'b0, ADD_, 32'd0, 32'd0);
    repeat (9) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1 check_reset_now("reset_mid_mul");
    @(negedge clk_i);
    rst_i = 1'b1;
    one_op("post_reset_add", ADD_, 32'd2, 32'd2, 32'd4, 1'b0);
    drive(1'b0, ADD_, 32'd0, 32'd0);
    v = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (bus.valid_o) v++;
    end
    check("no_stale_mul_valid", 64'(v), 64'd0);

    for (int it = 0; it < 600; it++) begin
      @(negedge clk_i);
      if (it == 300) begin
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
      end
      case ($urandom_range(0, 3))
        0:       a = 32'd0;
        1:       a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b);
    end
    drive(1'b0, ADD_, 32'd0, 32'd0);
    repeat (40) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; shift amount is the low log2(WIDTH) bits of data2_i.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i, input, 1: an operation request is present.
REQ-005 SHALL have port ALUCtrl_i, input, 3: operation code.
REQ-006 SHALL have port data1_i, input, WIDTH: operand 1 (rs1).
REQ-007 SHALL have port data2_i, input, WIDTH: operand 2 (rs2 or immediate).
REQ-008 SHALL have port ready_o, output, 1: the block can accept a request this cycle.
REQ-009 SHALL have port valid_o, output, 1: data_o holds a new result this cycle (one-cycle pulse).
REQ-010 SHALL have port data_o, output, WIDTH: registered result, held until the next result.
REQ-011 SHALL have port zero_o, output, 1: registered flag, 1 when the result written with the last valid_o is all zeros.

Function
REQ-012 SHALL decode ALUCtrl_i as follows:
- 000 AND: d1&d2
- 001 XOR: d1^d2
- 010 SLL: d1<<d2[4:0]
- 011 ADD: d1+d2
- 100 SUB: d1-d2
- 101 MUL: low WIDTH bits of d1*d2
- 110 ADDI: d1+d2
- 111 SRAI: arithmetic d1>>>d2[4:0]
REQ-013 SHALL discard carry/overflow in ADD, ADDI and SUB (modulo 2^WIDTH); MUL keeps only the low half.
REQ-014 SHALL accept a request on a rising edge where valid_i=1 and ready_o=1; requests presented while ready_o=0 are ignored and not queued.
REQ-015 SHALL implement the FSM states IDLE and MUL_BUSY; ready_o=1 if and only if the state is IDLE.
REQ-016 SHALL, for a non-MUL accept in IDLE, register the result into data_o and zero_o on the accepting edge, assert valid_o for the following cycle, and remain in IDLE (latency 1, throughput 1 per cycle).
REQ-017 SHALL, for a MUL accept, latch the multiplicand, multiplier, accumulator=0 and counter=0, and go to MUL_BUSY.
REQ-018 SHALL, in MUL_BUSY on each edge:
- if multiplier[0], accumulator += multiplicand;
- shift the multiplicand left 1 and the multiplier right 1;
- increment the counter.
REQ-019 SHALL, on the WIDTH-th MUL_BUSY edge, write the final accumulator to data_o and zero_o, pulse valid_o for one cycle, and return to IDLE (MUL latency = WIDTH edges after the accepting edge; 32 by default).
REQ-020 SHALL perform a fixed WIDTH iterations regardless of operand values (no early termination).
REQ-021 SHALL keep valid_o=0 in every cycle without a newly written result; data_o/zero_o SHALL NOT change except on a result write.
REQ-022 SHALL allow a new request to be accepted in the same cycle valid_o is high for the previous result.
REQ-023 SHALL ignore changes to data1_i, data2_i and ALUCtrl_i during MUL_BUSY.

Reset
REQ-024 SHALL, while rst_i=0, immediately force state=IDLE, data_o=0, zero_o=0, valid_o=0, counter=0 and accumulator=0; ready_o=1.
REQ-025 SHALL abandon any MUL in progress when reset is asserted; no valid_o is produced for it after reset is released.
REQ-026 SHALL accept a request on the first rising edge after rst_i returns to 1.

Verification
REQ-027 Reset: rst_i=0 mid-run -> data_o=0, valid_o=0, ready_o=1 without waiting for a clock edge.
REQ-028 Back-to-back single-cycle ops: ADD 5,3; then SUB 3,3; then AND F0F0F0F0,FF00FF00 on consecutive edges -> valid_o high 3 consecutive cycles with data_o 8, 0 (zero_o=1), F000F000.
REQ-029 Shifts: SLL 1,32'h21 -> 2; SRAI 80000000,4 -> F8000000; XOR FFFFFFFF,0F0F0F0F -> F0F0F0F0.
REQ-030 MUL: FFFFFFFF*FFFFFFFF -> ready_o=0 for 32 cycles, valid_o exactly 32 edges after the accept, data_o=00000001; 12345*0 -> 0 with zero_o=1.
REQ-031 Busy ignore: valid_i held at 1 with ADD 1,1 during a MUL 7*6 -> only the MUL result 42 (2A) appears; then ADD is accepted the cycle ready_o rises -> result 2.
REQ-032 Reset mid-MUL: rst_i=0 at iteration 10 of 3*4, then released -> no valid_o; a subsequent ADD 2,2 returns 4 at latency 1.
